// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: core load/store path vs. debug/loader port.
// The core has priority; a starvation counter forces a debug grant after MAX_WAIT losses.
module dmem_arbiter #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_core_req,
  input  logic              i_core_we,
  input  logic [ADDR_W-1:0] i_core_addr,
  input  logic [DATA_W-1:0] i_core_wd,
  output logic              o_core_stall,
  output logic              o_core_rvalid,
  output logic [DATA_W-1:0] o_core_rd,
  input  logic              i_dbg_req,
  input  logic              i_dbg_we,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  input  logic [DATA_W-1:0] i_dbg_wd,
  output logic              o_dbg_gnt,
  output logic              o_dbg_rvalid,
  output logic [DATA_W-1:0] o_dbg_rd,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wd,
  output logic              o_mem_wen,
  output logic              o_mem_ren,
  input  logic [DATA_W-1:0] i_mem_rd
);

  localparam int unsigned LAT_W  = 3;
  localparam int unsigned WAIT_W = 8;

  typedef enum logic {
    ST_IDLE,
    ST_RD_WAIT
  } state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;        // 1 = debug owns the outstanding read
  logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                dbg_prio_q, dbg_prio_d;

  logic                rvalid_any;
  logic                core_rvalid;
  logic                dbg_rvalid;
  logic                core_req_eff;
  logic                grant_dbg;
  logic                grant_core;
  logic                grant_we;
  logic [ADDR_W-1:0]   grant_addr;
  logic [DATA_W-1:0]   grant_wd;
  logic                stall;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= 1'b0;
      lat_cnt_q  <= '0;
      wait_cnt_q <= '0;
      dbg_prio_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      lat_cnt_q  <= lat_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      dbg_prio_q <= dbg_prio_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    lat_cnt_d  = lat_cnt_q;
    wait_cnt_d = wait_cnt_q;
    dbg_prio_d = dbg_prio_q;

    // Read data returns in the first IDLE cycle after the latency window.
    rvalid_any  = (state_q == ST_IDLE) && (lat_cnt_q == LAT_W'(1));
    core_rvalid = rvalid_any & ~owner_q;
    dbg_rvalid  = rvalid_any &  owner_q;

    // A core load completing this cycle must not be granted a second time.
    core_req_eff = i_core_req & ~core_rvalid;
    grant_dbg    = (state_q == ST_IDLE) & i_dbg_req & (dbg_prio_q | ~core_req_eff);
    grant_core   = (state_q == ST_IDLE) & core_req_eff & ~grant_dbg;

    grant_we   = grant_dbg ? i_dbg_we   : i_core_we;
    grant_addr = grant_dbg ? i_dbg_addr : i_core_addr;
    grant_wd   = grant_dbg ? i_dbg_wd   : i_core_wd;

    unique case (state_q)
      ST_IDLE: begin
        lat_cnt_d = '0;
        if ((grant_dbg | grant_core) & ~grant_we) begin
          owner_d   = grant_dbg;
          lat_cnt_d = LAT_W'(RD_LAT);
          if (RD_LAT > 1) begin
            state_d = ST_RD_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        lat_cnt_d = lat_cnt_q - LAT_W'(1);
        if (lat_cnt_q == LAT_W'(2)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Starvation counter saturates at MAX_WAIT and then forces the debug win.
    if (!i_dbg_req || grant_dbg) begin
      wait_cnt_d = '0;
      dbg_prio_d = 1'b0;
    end else begin
      if (wait_cnt_q < WAIT_W'(MAX_WAIT)) begin
        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      end
      dbg_prio_d = dbg_prio_q | (wait_cnt_d == WAIT_W'(MAX_WAIT));
    end

    stall = i_core_req & ~((grant_core & i_core_we) | core_rvalid);
  end

  // Outputs are forced low while reset is held.
  always_comb begin
    o_mem_addr    = '0;
    o_mem_wd      = '0;
    o_mem_wen     = 1'b0;
    o_mem_ren     = 1'b0;
    o_dbg_gnt     = 1'b0;
    o_core_stall  = 1'b0;
    o_core_rvalid = 1'b0;
    o_dbg_rvalid  = 1'b0;
    o_core_rd     = '0;
    o_dbg_rd      = '0;
    if (i_rst_n) begin
      if (grant_dbg | grant_core) begin
        o_mem_addr = grant_addr;
        o_mem_wd   = grant_wd;
        o_mem_wen  = grant_we;
        o_mem_ren  = ~grant_we;
      end
      o_dbg_gnt     = grant_dbg;
      o_core_stall  = stall;
      o_core_rvalid = core_rvalid;
      o_dbg_rvalid  = dbg_rvalid;
      o_core_rd     = core_rvalid ? i_mem_rd : '0;
      o_dbg_rd      = dbg_rvalid  ? i_mem_rd : '0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a
// transaction-level model (cycle numbers, loss count, word array).
module tb_dmem_arbiter;
  localparam int unsigned RD_LAT   = 2;
  localparam int unsigned MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req, core_we, dbg_req, dbg_we;
  logic [31:0] core_addr, core_wd, dbg_addr, dbg_wd;
  logic        core_stall, core_rvalid, dbg_gnt, dbg_rvalid, mem_wen, mem_ren;
  logic [31:0] core_rd, dbg_rd, mem_addr, mem_wd, mem_rd;

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_core_req(core_req), .i_core_we(core_we), .i_core_addr(core_addr), .i_core_wd(core_wd),
    .o_core_stall(core_stall), .o_core_rvalid(core_rvalid), .o_core_rd(core_rd),
    .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr), .i_dbg_wd(dbg_wd),
    .o_dbg_gnt(dbg_gnt), .o_dbg_rvalid(dbg_rvalid), .o_dbg_rd(dbg_rd),
    .o_mem_addr(mem_addr), .o_mem_wd(mem_wd), .o_mem_wen(mem_wen), .o_mem_ren(mem_ren),
    .i_mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Memory environment driven by the DUT's port.
  logic [31:0] mem_env [16];
  logic        sched_v [8];
  logic [31:0] sched_d [8];

  // Reference model state.
  logic [31:0] mem_ref [16];
  int          busy_until = 0;
  int          rd_due = -1;
  logic        rd_own = 1'b0;
  logic [31:0] rd_data = '0;
  int          losses = 0;

  // Observations for the stimulus agents and directed checks.
  logic        obs_stall, obs_gnt, obs_crv, obs_drv, obs_ren, obs_wen;
  logic [31:0] obs_crd, obs_drd, obs_addr, obs_wd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: present memory data, check against the model, then commit.
  task automatic step();
    int          win;
    logic        core_rv, dbg_rv, core_eff, e_we;
    logic [31:0] e_addr, e_wd;
    @(negedge clk);
    mem_rd = sched_v[cyc % 8] ? sched_d[cyc % 8] : $urandom;
    #1;
    core_rv = rst_n && (rd_due == cyc) && !rd_own;
    dbg_rv  = rst_n && (rd_due == cyc) &&  rd_own;
    win = 0;
    if (rst_n && cyc >= busy_until) begin
      core_eff = core_req && !core_rv;
      if (dbg_req && (losses >= int'(MAX_WAIT) || !core_eff)) win = 2;
      else if (core_eff) win = 1;
    end
    e_addr = (win == 1) ? core_addr : (win == 2) ? dbg_addr : 32'h0;
    e_wd   = (win == 1) ? core_wd   : (win == 2) ? dbg_wd   : 32'h0;
    e_we   = (win == 1) ? core_we   : (win == 2) ? dbg_we   : 1'b0;
    check("mem_addr", mem_addr, e_addr);
    check("mem_wd", mem_wd, e_wd);
    check("mem_wen", 32'(mem_wen), 32'(win != 0 && e_we));
    check("mem_ren", 32'(mem_ren), 32'(win != 0 && !e_we));
    check("dbg_gnt", 32'(dbg_gnt), 32'(win == 2));
    check("core_stall", 32'(core_stall),
          32'(rst_n && core_req && !((win == 1 && core_we) || core_rv)));
    check("core_rvalid", 32'(core_rvalid), 32'(core_rv));
    check("core_rd", core_rd, core_rv ? rd_data : 32'h0);
    check("dbg_rvalid", 32'(dbg_rvalid), 32'(dbg_rv));
    check("dbg_rd", dbg_rd, dbg_rv ? rd_data : 32'h0);
    obs_stall = core_stall; obs_gnt = dbg_gnt; obs_crv = core_rvalid; obs_drv = dbg_rvalid;
    obs_crd = core_rd; obs_drd = dbg_rd; obs_ren = mem_ren; obs_wen = mem_wen;
    obs_addr = mem_addr; obs_wd = mem_wd;
    @(posedge clk);
    sched_v[cyc % 8] = 1'b0;
    if (obs_wen) mem_env[obs_addr[5:2]] = obs_wd;
    if (obs_ren) begin
      sched_v[(cyc + int'(RD_LAT)) % 8] = 1'b1;
      sched_d[(cyc + int'(RD_LAT)) % 8] = mem_env[obs_addr[5:2]];
    end
    if (!rst_n) begin
      busy_until = 0; rd_due = -1; losses = 0;
    end else begin
      losses = (dbg_req && win != 2) ? ((losses < int'(MAX_WAIT)) ? losses + 1 : losses) : 0;
      if (win != 0 && e_we) mem_ref[e_addr[5:2]] = e_wd;
      if (win != 0 && !e_we) begin
        busy_until = cyc + int'(RD_LAT);
        rd_due     = cyc + int'(RD_LAT);
        rd_own     = (win == 2);
        rd_data    = mem_ref[e_addr[5:2]];
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    core_req = 0; core_we = 0; core_addr = 0; core_wd = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wd = 0;
  endtask

  initial begin
    int gnt_at;
    for (int i = 0; i < 16; i++) begin mem_env[i] = '0; mem_ref[i] = '0; end
    for (int i = 0; i < 8; i++) begin sched_v[i] = 1'b0; sched_d[i] = '0; end
    idle_inputs();
    mem_rd = '0;
    rst_n = 0;
    #1;
    check("rst_stall", 32'(core_stall), 32'h0);
    check("rst_ren", 32'(mem_ren), 32'h0);
    repeat (2) step();
    rst_n = 1;
    step();

    // Core store then core load of the same word.
    core_req = 1; core_we = 1; core_addr = 32'h10; core_wd = 32'hDEADBEEF;
    step();
    check("t1_wen", 32'(obs_wen), 32'h1);
    check("t1_stall", 32'(obs_stall), 32'h0);
    core_we = 0; core_wd = 0;
    step(); check("t2_stall0", 32'(obs_stall), 32'h1);
    step(); check("t2_stall1", 32'(obs_stall), 32'h1);
    step();
    check("t2_rvalid", 32'(obs_crv), 32'h1);
    check("t2_rd", obs_crd, 32'hDEADBEEF);
    check("t2_stall2", 32'(obs_stall), 32'h0);
    idle_inputs(); step();

    // Simultaneous requests, then core stores every cycle until debug is forced in.
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h10;
    gnt_at = -1;
    for (int i = 0; i < 20; i++) begin
      core_req = 1; core_we = 1; core_addr = 32'h4 * (i % 4); core_wd = $urandom;
      step();
      if (i == 0) check("t3_gnt", 32'(obs_gnt), 32'h0);
      if (obs_gnt) begin
        gnt_at = i;
        check("t4_stall", 32'(obs_stall), 32'h1);
        break;
      end
    end
    check("t4_gnt_cycle", gnt_at, 32'(MAX_WAIT));
    idle_inputs(); repeat (3) step();

    // Debug write/read of 0x20, core load issued back-to-back with the debug return.
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h20; dbg_wd = 32'h12345678;
    step(); check("t5_wgnt", 32'(obs_gnt), 32'h1);
    dbg_we = 0; dbg_wd = 0;
    step(); check("t5_rgnt", 32'(obs_gnt), 32'h1);
    dbg_req = 0; core_req = 1; core_we = 0; core_addr = 32'h10;
    step();
    step();
    check("t5_drv", 32'(obs_drv), 32'h1);
    check("t5_drd", obs_drd, 32'h12345678);
    check("t5_core_ren", 32'(obs_ren), 32'h1);
    repeat (2) step();
    idle_inputs(); step();

    // Reset while a core read is outstanding.
    core_req = 1; core_we = 0; core_addr = 32'h20;
    step();
    rst_n = 0;
    #1;
    check("t6_stall", 32'(core_stall), 32'h0);
    check("t6_ren", 32'(mem_ren), 32'h0);
    step();
    rst_n = 1; core_req = 0;
    repeat (3) step();
    core_req = 1;
    repeat (4) step();
    idle_inputs(); step();

    // Random traffic with hold-until-accepted agents.
    for (int n = 0; n < 4000; n++) begin
      if (core_req && !obs_stall) core_req = 0;
      if (!core_req && $urandom_range(0, 99) < 60) begin
        core_req = 1; core_we = 1'($urandom_range(0, 1));
        core_addr = 32'($urandom_range(0, 15)) << 2; core_wd = $urandom;
      end
      if (dbg_req && obs_gnt) dbg_req = 0;
      else if (dbg_req && $urandom_range(0, 99) < 3) dbg_req = 0;
      if (!dbg_req && $urandom_range(0, 99) < 30) begin
        dbg_req = 1; dbg_we = 1'($urandom_range(0, 1));
        dbg_addr = 32'($urandom_range(0, 15)) << 2; dbg_wd = $urandom;
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
